// File: rtl/adder_arbiter_pkg.sv
// Shared constants and helpers for the adder_arbiter block.
package adder_arbiter_pkg;

  localparam int DEF_N    = 32;
  localparam int DEF_NREQ = 4;
  localparam int CNT_W    = 16;

  // Width of a requester index; never below one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin grant selection: search starts one past last_grant and wraps.
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (j == idx) && req[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/full_adder.sv
// N-bit ripple-carry adder with carry-in and carry-out.
module full_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin : ripple
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shared ripple-carry adder with round-robin arbitration and a one-deep result register.
// Define ADDER_ARBITER_STATS_EN to add per-requester saturating grant counters (grant_cnt).
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter  int N    = DEF_N,
  parameter  int NREQ = DEF_NREQ,
  localparam int IDW  = id_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic [IDW-1:0]    rsp_id
`ifdef ADDER_ARBITER_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  logic [IDW-1:0]  last_grant;
  logic [NREQ-1:0] grant;
  logic            slot_free;
  logic            transfer;
  logic [N-1:0]    sel_a, sel_b, add_sum;
  logic            sel_cin, add_cout;
  logic [IDW-1:0]  sel_id;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign slot_free = !rsp_valid | rsp_ready;
  // Ready is also gated by rst so nothing is accepted while reset is held.
  assign req_ready = (slot_free && !rst) ? grant : '0;
  assign transfer  = |req_ready;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    sel_id  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant[j]) begin
        sel_a   = req_a[j*N +: N];
        sel_b   = req_b[j*N +: N];
        sel_cin = req_cin[j];
        sel_id  = IDW'(j);
      end
    end
  end

  full_adder #(.N(N)) u_add (
    .a    (sel_a),
    .b    (sel_b),
    .cin  (sel_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else if (transfer) begin
      rsp_valid  <= 1'b1;
      rsp_sum    <= add_sum;
      rsp_cout   <= add_cout;
      rsp_id     <= sel_id;
      last_grant <= sel_id;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef ADDER_ARBITER_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_ready[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NREQ; k++) begin : g_cnt
    assign grant_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (N=32, NREQ=4).
module tb_adder_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [1:0]        rsp_id;
`ifdef ADDER_ARBITER_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
`ifdef ADDER_ARBITER_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [1:0] id,
                           input logic [31:0] sum, input logic cout);
    check({tag, "_valid"}, 64'(rsp_valid), 64'(v));
    check({tag, "_id"},    64'(rsp_id),    64'(id));
    check({tag, "_sum"},   64'(rsp_sum),   64'(sum));
    check({tag, "_cout"},  64'(rsp_cout),  64'(cout));
  endtask

  logic [3:0]  exp_rdy [5];
  logic [1:0]  exp_id  [5];
  logic [31:0] exp_sum [5];

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_cin   = 4'h0;
    // requester k: a = 0x100*(k+1), b = k
    req_a = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    req_b = {32'd3, 32'd2, 32'd1, 32'd0};

    tick(); tick();
    check_rsp("reset", 1'b0, 2'd0, 32'h0, 1'b0);
    check("reset_ready", 64'(req_ready), 64'h0);

    // Round-robin with everyone requesting: 0,1,2,3,0
    rst = 1'b0;
    #1;
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_sum = '{32'h100, 32'h201, 32'h302, 32'h403, 32'h100};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_ready%0d", i), 64'(req_ready), 64'(exp_rdy[i]));
      tick();
      check_rsp($sformatf("rr_rsp%0d", i), 1'b1, exp_id[i], exp_sum[i], 1'b0);
    end

    // Backpressure: result held, nothing accepted
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold_ready%0d", i), 64'(req_ready), 64'h0);
      check_rsp($sformatf("hold_rsp%0d", i), 1'b1, 2'd0, 32'h100, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("release_ready", 64'(req_ready), 64'b0010);
    tick();
    check_rsp("release_rsp", 1'b1, 2'd1, 32'h201, 1'b0);

    // Single requester at full throughput
    req_valid = 4'b0100;
    req_a[2*N +: N] = 32'd5;
    req_b[2*N +: N] = 32'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("solo_ready%0d", i), 64'(req_ready), 64'b0100);
      tick();
      check_rsp($sformatf("solo_rsp%0d", i), 1'b1, 2'd2, 32'd12, 1'b0);
    end

    // Overflow wrap
    req_valid = 4'b0001;
    req_a[0 +: N] = 32'hFFFF_FFFF;
    req_b[0 +: N] = 32'h0;
    req_cin = 4'b0001;
    #1;
    check("wrap_ready", 64'(req_ready), 64'b0001);
    tick();
    check_rsp("wrap_rsp", 1'b1, 2'd0, 32'h0, 1'b1);

    // Drain with no new request
    req_valid = 4'b0000;
    req_cin   = 4'b0000;
    tick();
    check("drain_valid", 64'(rsp_valid), 64'h0);

    // Empty slot accepts even with rsp_ready low, then holds
    req_a[0 +: N] = 32'd9;
    req_b[0 +: N] = 32'd1;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    check("empty_ready", 64'(req_ready), 64'b0001);
    tick();
    check_rsp("empty_rsp", 1'b1, 2'd0, 32'd10, 1'b0);

    // Asynchronous reset while a result is held
    rst = 1'b1;
    #1;
    check_rsp("arst", 1'b0, 2'd0, 32'h0, 1'b0);
    check("arst_ready", 64'(req_ready), 64'h0);
    tick();
    rst       = 1'b0;
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'b0010);
    tick();
    check_rsp("post_rst_rsp1", 1'b1, 2'd1, 32'h201, 1'b0);
    check("post_rst_ready2", 64'(req_ready), 64'b1000);
    tick();
    check_rsp("post_rst_rsp3", 1'b1, 2'd3, 32'h403, 1'b0);

`ifdef ADDER_ARBITER_STATS_EN
    rst = 1'b1;
    tick();
    check("cnt_reset", 64'(grant_cnt), 64'h0);
    rst       = 1'b0;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    check("cnt_sat0", 64'(grant_cnt[15:0]), 64'hFFFF);
    check("cnt_others", 64'(grant_cnt[63:16]), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, operand width per requester.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ, per-requester operation valid.
REQ-006 SHALL have port req_ready, output, NREQ, per-requester accept (one-hot or zero).
REQ-007 SHALL have port req_a, input, NREQ*N, operand A; requester k occupies bits [k*N +: N].
REQ-008 SHALL have port req_b, input, NREQ*N, operand B, same packing as req_a.
REQ-009 SHALL have port req_cin, input, NREQ, per-requester carry-in.
REQ-010 SHALL have port rsp_valid, output, 1, result register holds a valid result.
REQ-011 SHALL have port rsp_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port rsp_sum, output, N, registered sum.
REQ-013 SHALL have port rsp_cout, output, 1, registered carry-out.
REQ-014 SHALL have port rsp_id, output, clog2(NREQ), index of the requester that owns the result.

Function
REQ-015 SHALL share one N-bit ripple-carry adder among all requesters; a transfer occurs on requester k when req_valid[k] and req_ready[k] are both high.
REQ-016 SHALL assert at most one req_ready bit per cycle, and only when slot_free = !rsp_valid | rsp_ready.
REQ-017 SHALL select the grant round-robin: search starts at index last_grant+1 mod NREQ; the first requester with req_valid high wins.
REQ-018 SHALL update last_grant only on a completed transfer; with no transfer, priority is unchanged.
REQ-019 SHALL register {sum, cout, id} of the granted operands at the transfer edge; rsp_valid rises the next cycle (latency 1).
REQ-020 SHALL hold rsp_sum, rsp_cout and rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL, on a cycle where rsp_valid=1, rsp_ready=1 and a new transfer occurs, replace the result with no bubble (full throughput: 1 op/cycle).
REQ-022 SHALL clear rsp_valid after rsp_ready=1 when no new transfer occurs that cycle.
REQ-023 SHALL compute rsp_cout as the carry out of bit N-1; an overflow wrap (all-ones + 1) gives sum 0, cout 1.
REQ-024 SHALL allow req_ready to depend combinationally on req_valid and rsp_ready; no other input-to-output combinational path is permitted.

Reset
REQ-025 SHALL, while rst=1, force rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, last_grant=NREQ-1 (requester 0 has top priority first), and req_ready=0.
REQ-026 SHALL, on reset assertion mid-operation, discard any held result without emitting it; the first grant after release goes to the lowest-index valid requester.

Configuration
REQ-027 SHALL, when ADDER_ARBITER_STATS_EN is defined, add an output grant_cnt (NREQ*16) holding per-requester 16-bit grant counters: each counter increments on its requester's transfer, saturates at 0xFFFF, and resets to 0.
REQ-028 SHALL, when ADDER_ARBITER_STATS_EN is undefined, omit the grant_cnt port and counters entirely, with otherwise identical behaviour.

Structure
REQ-029 SHALL place the ID width function (clog2), the default N/NREQ constants and the counter width constant (16) in shared package adder_arbiter_pkg.
REQ-030 SHALL implement grant selection in one sub-module rr_arbiter (request vector, last_grant in; one-hot grant out); the adder is an instance of the existing full_adder with N passed through.

Verification
REQ-031 SHALL cover: after reset, all req_valid=1, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, rsp_id the same sequence one cycle later.
REQ-032 SHALL cover: N=32, req0 a=0xFFFFFFFF, b=0, cin=1 -> rsp_sum=0x00000000, rsp_cout=1, rsp_id=0.
REQ-033 SHALL cover: rsp_ready=0 for 5 cycles with a result held and req_valid=0xF -> req_ready=0 and rsp outputs stable throughout; first grant after release follows round-robin order.
REQ-034 SHALL cover: only req2 valid, continuous rsp_ready=1 -> req2 granted every cycle, 1 op/cycle, a=5, b=7, cin=0 -> sum 12.
REQ-035 SHALL cover: rst asserted while rsp_valid=1 -> rsp_valid=0 immediately (asynchronous), with no response emitted; after release with req_valid=0b1010 -> first grant to req1.
REQ-036 SHALL cover, with ADDER_ARBITER_STATS_EN defined: 70000 grants to req0 -> grant_cnt[0]=0xFFFF, others 0.
